// File: rtl/alu_issue_unit_pkg.sv
// Shared RV32I decode constants and the issue-unit state encoding.
// funct3 values match the downstream ALU's operation select.
package rv32i_defs;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_FAULT     = 3'd4
    } issue_state_e;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction, ALU, retire and debug signals of the issue unit.
// The unit uses the master modport; fetch/ALU/debug side uses slave.
interface alu_issue_unit_if #(parameter int XLEN = 32);

    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instruction;
    logic            alu_enable;
    logic [2:0]      alu_funct3;
    logic [XLEN-1:0] alu_operand_1;
    logic [XLEN-1:0] alu_operand_2;
    logic [XLEN-1:0] alu_result;
    logic            retire_valid;
    logic [4:0]      retire_rd;
    logic [XLEN-1:0] retire_data;
    logic            illegal;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        input  instr_valid, instruction, alu_result, dbg_addr,
        output instr_ready, alu_enable, alu_funct3, alu_operand_1, alu_operand_2,
        output retire_valid, retire_rd, retire_data, illegal, dbg_data
    );

    modport slave (
        output instr_valid, instruction, alu_result, dbg_addr,
        input  instr_ready, alu_enable, alu_funct3, alu_operand_1, alu_operand_2,
        input  retire_valid, retire_rd, retire_data, illegal, dbg_data
    );

endinterface

// File: rtl/alu_issue_unit_decoder.sv
// Combinational RV32I OP / OP-IMM decoder feeding the issue unit.
// SUB is issued as ADD with a negated rs2; SRA/SRAI are rejected.
module rv32i_alu_decoder
    import rv32i_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            use_imm,
    output logic [XLEN-1:0] imm,
    output logic            negate_rs2,
    output logic            shift_mask,
    output logic            unsupported
);

    logic [6:0] opcode_s;
    logic [6:0] funct7_s;

    assign opcode_s = instruction[6:0];
    assign funct7_s = instruction[31:25];
    assign funct3   = instruction[14:12];
    assign rd       = instruction[11:7];
    assign rs1      = instruction[19:15];
    assign rs2      = instruction[24:20];
    assign imm      = {{(XLEN-12){instruction[31]}}, instruction[31:20]};

    // Classify the instruction and select operand-2 handling
    always_comb begin
        use_imm     = 1'b0;
        negate_rs2  = 1'b0;
        shift_mask  = 1'b0;
        unsupported = 1'b1;
        case (opcode_s)
            OPCODE_OP_IMM: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_SLL, F3_SRL: begin
                        // imm[11:5] doubles as funct7; only the logical shifts exist here
                        shift_mask  = 1'b1;
                        unsupported = (funct7_s != F7_BASE);
                    end
                    default: unsupported = 1'b0;
                endcase
            end
            OPCODE_OP: begin
                if (funct7_s == F7_BASE) begin
                    unsupported = 1'b0;
                    shift_mask  = (funct3 == F3_SLL) || (funct3 == F3_SRL);
                end else if ((funct7_s == F7_ALT) && (funct3 == F3_ADD)) begin
                    unsupported = 1'b0;
                    negate_rs2  = 1'b1;
                end else begin
                    unsupported = 1'b1;
                end
            end
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the RV32I ALU: accepts one instruction, reads the
// register file, drives the ALU for two cycles and writes the result back.
module alu_issue_unit
    import rv32i_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clock,
    input  logic          reset,
    alu_issue_unit_if.master bus
);

    logic [XLEN-1:0] rf_r [NREGS];

    issue_state_e    state_r;
    logic            instr_ready_r;
    logic            alu_enable_r;
    logic [2:0]      alu_funct3_r;
    logic [XLEN-1:0] alu_operand_1_r;
    logic [XLEN-1:0] alu_operand_2_r;
    logic [4:0]      rd_r;
    logic            retire_valid_r;
    logic [4:0]      retire_rd_r;
    logic [XLEN-1:0] retire_data_r;
    logic            illegal_r;

    logic [2:0]      dec_funct3_s;
    logic [4:0]      dec_rs1_s;
    logic [4:0]      dec_rs2_s;
    logic [4:0]      dec_rd_s;
    logic            dec_use_imm_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_negate_rs2_s;
    logic            dec_shift_mask_s;
    logic            dec_unsupported_s;

    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic [XLEN-1:0] op2_sel_s;
    logic [XLEN-1:0] op2_s;

    rv32i_alu_decoder #(.XLEN(XLEN)) u_decoder (
        .instruction (bus.instruction),
        .funct3      (dec_funct3_s),
        .rs1         (dec_rs1_s),
        .rs2         (dec_rs2_s),
        .rd          (dec_rd_s),
        .use_imm     (dec_use_imm_s),
        .imm         (dec_imm_s),
        .negate_rs2  (dec_negate_rs2_s),
        .shift_mask  (dec_shift_mask_s),
        .unsupported (dec_unsupported_s)
    );

    assign rs1_val_s = (dec_rs1_s == 5'd0) ? {XLEN{1'b0}} : rf_r[dec_rs1_s];
    assign rs2_val_s = (dec_rs2_s == 5'd0) ? {XLEN{1'b0}} : rf_r[dec_rs2_s];

    // Select operand 2: immediate, negated rs2 (SUB) or plain rs2
    always_comb begin
        op2_sel_s = rs2_val_s;
        if (dec_use_imm_s) begin
            op2_sel_s = dec_imm_s;
        end else if (dec_negate_rs2_s) begin
            op2_sel_s = (~rs2_val_s) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            op2_sel_s = rs2_val_s;
        end
    end

    // The ALU shifts by its whole operand, so shift amounts are trimmed here
    assign op2_s = dec_shift_mask_s ? {{(XLEN-5){1'b0}}, op2_sel_s[4:0]} : op2_sel_s;

    // Issue FSM with all handshake, ALU and retire outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            instr_ready_r   <= 1'b1;
            alu_enable_r    <= 1'b0;
            alu_funct3_r    <= 3'b000;
            alu_operand_1_r <= {XLEN{1'b0}};
            alu_operand_2_r <= {XLEN{1'b0}};
            rd_r            <= 5'd0;
            retire_valid_r  <= 1'b0;
            retire_rd_r     <= 5'd0;
            retire_data_r   <= {XLEN{1'b0}};
            illegal_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_ready_r <= 1'b0;
                        rd_r          <= dec_rd_s;
                        if (dec_unsupported_s) begin
                            state_r   <= ST_FAULT;
                            illegal_r <= 1'b1;
                        end else begin
                            state_r         <= ST_ISSUE;
                            alu_enable_r    <= 1'b1;
                            alu_funct3_r    <= dec_funct3_s;
                            alu_operand_1_r <= rs1_val_s;
                            alu_operand_2_r <= op2_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_r        <= ST_WRITEBACK;
                    alu_enable_r   <= 1'b0;
                    retire_valid_r <= 1'b1;
                    retire_rd_r    <= rd_r;
                    retire_data_r  <= bus.alu_result;
                end
                ST_WRITEBACK: begin
                    state_r        <= ST_IDLE;
                    retire_valid_r <= 1'b0;
                    instr_ready_r  <= 1'b1;
                end
                ST_FAULT: begin
                    state_r       <= ST_IDLE;
                    illegal_r     <= 1'b0;
                    instr_ready_r <= 1'b1;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    instr_ready_r  <= 1'b1;
                    alu_enable_r   <= 1'b0;
                    retire_valid_r <= 1'b0;
                    illegal_r      <= 1'b0;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written at the end of WRITEBACK
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if ((state_r == ST_WRITEBACK) && (retire_rd_r != 5'd0)) begin
            rf_r[retire_rd_r] <= retire_data_r;
        end
    end

    assign bus.instr_ready   = instr_ready_r;
    assign bus.alu_enable    = alu_enable_r;
    assign bus.alu_funct3    = alu_funct3_r;
    assign bus.alu_operand_1 = alu_operand_1_r;
    assign bus.alu_operand_2 = alu_operand_2_r;
    assign bus.retire_valid  = retire_valid_r;
    assign bus.retire_rd     = retire_rd_r;
    assign bus.retire_data   = retire_data_r;
    assign bus.illegal       = illegal_r;
    assign bus.dbg_data      = (bus.dbg_addr == 5'd0) ? {XLEN{1'b0}} : rf_r[bus.dbg_addr];

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Front end for the RV32I integer ALU: accepts one 32-bit instruction via valid/ready, decodes OP / OP-IMM, and reads operands from an internal 32x32 register file.
- Drives the ALU's enable, funct3 and operand inputs, captures the ALU result, and writes it back to rd.
- Sits between fetch and the existing ALU; it is the producer side of the ALU's funct3/operand interface.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register file depth; x0 is hardwired to zero.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present on instruction
- instr_ready  output  1  unit can accept an instruction this cycle
- instruction  input  32  RV32I instruction word
- alu_enable  output  1  ALU enable
- alu_funct3  output  3  ALU operation select
- alu_operand_1  output  32  ALU register_data_1
- alu_operand_2  output  32  ALU register_data_2
- alu_result  input  32  ALU register_data_out
- retire_valid  output  1  one-cycle pulse: instruction completed and written back
- retire_rd  output  5  destination register of the retiring instruction
- retire_data  output  32  value written to rd
- illegal  output  1  one-cycle pulse: accepted instruction unsupported, discarded
- dbg_addr  input  5  debug register-file read address
- dbg_data  output  32  combinational read of rf[dbg_addr]; 0 when dbg_addr = 0

Behaviour:
- Reset:
  - State goes to IDLE; all register-file entries clear to 0.
  - instr_ready=1 in IDLE; alu_enable, retire_valid and illegal are 0.
  - alu_funct3, alu_operand_1, alu_operand_2, retire_rd and retire_data are 0.
- FSM states: IDLE, ISSUE, CAPTURE, WRITEBACK, FAULT.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch instruction and decode.
  - Supported instruction: latch rs1/rs2/imm operands, then go to ISSUE. Unsupported instruction: go to FAULT.
- Decode:
  - OP-IMM (opcode 0010011):
    - operand_2 = sign-extended imm[11:0].
    - SLLI/SRLI require imm[11:5]=0; SRAI is unsupported.
  - OP (opcode 0110011):
    - funct7=0000000 gives all eight funct3 operations.
    - funct7=0100000 with funct3=000 is SUB: issue as ADD with operand_2 = two's-complement negation of rs2.
    - SRA and every other funct7 value are unsupported.
  - Any other opcode is unsupported.
- Shifts: operand_2 is masked to bits [4:0], upper bits zero. The ALU shifts by the full operand, so this masking is mandatory.
- ISSUE:
  - alu_enable=1; funct3 and operands are driven from the latched values.
  - The ALU registers its result on this edge.
- CAPTURE:
  - alu_enable stays 1 with operands unchanged, so the ALU output holds the same value.
  - alu_result is sampled into the result register at the end of this cycle.
- WRITEBACK:
  - alu_enable=0; retire_valid=1 with retire_rd and retire_data.
  - rf[rd] is written unless rd=0.
  - Next state is IDLE.
- FAULT: illegal=1 for one cycle; no register write, no ALU enable; next state IDLE.
- Latency and throughput:
  - Accept at edge N, retire_valid high in cycle N+3, instr_ready high again in cycle N+4.
  - Throughput is one instruction per 4 cycles.
  - instr_ready=0 in every state except IDLE.
- Operand read: occurs in the accept cycle, from the register file as written by prior retires. No hazards exist because there is only one instruction in flight.
- x0: reads return 0 regardless of storage; writes with rd=0 still pulse retire_valid, with retire_data showing the discarded result.
- Debug port: a dbg_addr read of the register being written in WRITEBACK returns the old value that cycle and the new value the next cycle.
- Reset mid-operation: in-flight instruction abandoned, no writeback or retire pulse, alu_enable drops in the cycle after the reset edge.
- alu_result is ignored outside CAPTURE; the ALU's high-impedance output in other states has no effect.

Decomposition:
- Shared package rv32i_defs holds:
  - opcode constants OP=0110011 and OP_IMM=0010011;
  - funct3 encodings ADD..AND, matching the ALU's;
  - funct7 values 0000000 and 0100000;
  - FSM state enum.
- One natural sub-module: rv32i_alu_decoder. It is combinational: instruction in; funct3, rs1, rs2, rd, use_imm, imm, negate_rs2, shift_mask and unsupported out.
- The register file and FSM stay in alu_issue_unit.

Test Plan:
- Reset, then dbg_addr sweep 0..31 -> all dbg_data 0; instr_ready=1, alu_enable=0.
- ADDI x1,x0,5 then ADDI x2,x0,-3 -> retires x1=0x00000005 and x2=0xFFFFFFFD; each retire_valid exactly 3 cycles after accept.
- ADD x3,x1,x2 then SUB x4,x1,x2 -> x3=0x00000002, x4=0x00000008; alu_funct3=000 and alu_enable high for exactly 2 cycles each.
- SLT x5,x2,x1 -> 1; SLTU x6,x2,x1 -> 0; SLL x7,x1,x8 with x8=0x00000021 -> operand_2=1, x7=0x0000000A.
- SRA, SRAI, SLLI with imm[11:5]=0000001, and opcode 0000011 -> illegal pulses once each, no retire_valid, register file unchanged.
- ADDI x0,x0,7 -> retire_valid with retire_data=7, x0 still reads 0.
- Reset asserted during CAPTURE of ADDI x9,x0,1 -> no retire_valid, x9=0.
